// File: rtl/find_axis_least_penetration_pkg.sv
// find_axis_least_penetration_pkg: widths, counts and state encoding shared by the narrow-phase stages
package find_axis_least_penetration_pkg;
  localparam int W = 10;
  localparam int DOT_W = 2 * W + 1;
  localparam int PEN_W = 2 * W + 2;
  localparam int NUM_FACES = 4;
  localparam int NUM_VERTS = 4;
  typedef enum logic [1:0] {IDLE, SCAN, EVAL, DONE} state_t;
endpackage

// File: rtl/find_axis_least_penetration_dot2.sv
// dot2_signed: combinational 2-D signed dot product with full-precision result
module dot2_signed
  import find_axis_least_penetration_pkg::*;
(
  input  logic signed [W-1:0]     ax,
  input  logic signed [W-1:0]     ay,
  input  logic signed [W-1:0]     bx,
  input  logic signed [W-1:0]     by,
  output logic signed [DOT_W-1:0] d
);
  assign d = DOT_W'(ax * bx) + DOT_W'(ay * by);
endmodule

// File: rtl/find_axis_least_penetration.sv
// find_axis_least_penetration: picks the face of A along which B penetrates least
module find_axis_least_penetration
  import find_axis_least_penetration_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [W-1:0]     normA0_x,
  input  logic signed [W-1:0]     normA1_x,
  input  logic signed [W-1:0]     normA2_x,
  input  logic signed [W-1:0]     normA3_x,
  input  logic signed [W-1:0]     normA0_y,
  input  logic signed [W-1:0]     normA1_y,
  input  logic signed [W-1:0]     normA2_y,
  input  logic signed [W-1:0]     normA3_y,
  input  logic signed [W-1:0]     vertA0_x,
  input  logic signed [W-1:0]     vertA1_x,
  input  logic signed [W-1:0]     vertA2_x,
  input  logic signed [W-1:0]     vertA3_x,
  input  logic signed [W-1:0]     vertA0_y,
  input  logic signed [W-1:0]     vertA1_y,
  input  logic signed [W-1:0]     vertA2_y,
  input  logic signed [W-1:0]     vertA3_y,
  input  logic signed [W-1:0]     vertB0_x,
  input  logic signed [W-1:0]     vertB1_x,
  input  logic signed [W-1:0]     vertB2_x,
  input  logic signed [W-1:0]     vertB3_x,
  input  logic signed [W-1:0]     vertB0_y,
  input  logic signed [W-1:0]     vertB1_y,
  input  logic signed [W-1:0]     vertB2_y,
  input  logic signed [W-1:0]     vertB3_y,
  output logic signed [W-1:0]     referenceNorm_x,
  output logic signed [W-1:0]     referenceNorm_y,
  output logic [1:0]              referenceIndex,
  output logic signed [PEN_W-1:0] bestPenetration,
  output logic                    separating,
  output logic                    done_out
);
  state_t state;
  logic [1:0] face, vert;
  logic signed [DOT_W-1:0] min_dot, bdot, adot, dmin;
  logic signed [PEN_W-1:0] pen;
  logic signed [W-1:0] n_x [NUM_FACES];
  logic signed [W-1:0] n_y [NUM_FACES];
  logic signed [W-1:0] a_x [NUM_FACES];
  logic signed [W-1:0] a_y [NUM_FACES];
  logic signed [W-1:0] b_x [NUM_VERTS];
  logic signed [W-1:0] b_y [NUM_VERTS];
  assign n_x = '{normA0_x, normA1_x, normA2_x, normA3_x};
  assign n_y = '{normA0_y, normA1_y, normA2_y, normA3_y};
  assign a_x = '{vertA0_x, vertA1_x, vertA2_x, vertA3_x};
  assign a_y = '{vertA0_y, vertA1_y, vertA2_y, vertA3_y};
  assign b_x = '{vertB0_x, vertB1_x, vertB2_x, vertB3_x};
  assign b_y = '{vertB0_y, vertB1_y, vertB2_y, vertB3_y};
  dot2_signed u_bdot (.ax(n_x[face]), .ay(n_y[face]), .bx(b_x[vert]), .by(b_y[vert]), .d(bdot));
  dot2_signed u_adot (.ax(n_x[face]), .ay(n_y[face]), .bx(a_x[face]), .by(a_y[face]), .d(adot));
  always_comb begin
    dmin = (vert == 2'd0 || bdot < min_dot) ? bdot : min_dot;
    pen = PEN_W'(min_dot) - PEN_W'(adot);
    referenceNorm_x = n_x[referenceIndex];
    referenceNorm_y = n_y[referenceIndex];
    separating = ~bestPenetration[PEN_W-1];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      face <= '0;
      vert <= '0;
      min_dot <= '0;
      referenceIndex <= '0;
      bestPenetration <= '0;
      done_out <= 1'b0;
    end else if (start) begin
      state <= SCAN;
      face <= '0;
      vert <= '0;
      done_out <= 1'b0;
    end else if (state == SCAN) begin
      min_dot <= dmin;
      vert <= vert + 2'd1;
      if (vert == 2'd3) state <= EVAL;
    end else if (state == EVAL) begin
      // strict compare keeps the lowest face index on ties
      if (face == 2'd0 || pen > bestPenetration) begin
        bestPenetration <= pen;
        referenceIndex <= face;
      end
      vert <= '0;
      face <= face + 2'd1;
      state <= (face == 2'd3) ? DONE : SCAN;
      done_out <= (face == 2'd3);
    end
  end
endmodule

// File: tb/tb_find_axis_least_penetration.sv
// tb_find_axis_least_penetration: directed checks of face selection, latency, restart and reset
module tb_find_axis_least_penetration;
  import find_axis_least_penetration_pkg::*;
  logic clk = 0, rst = 0, start = 0;
  logic signed [W-1:0] nax [4], nay [4], vax [4], vay [4], vbx [4], vby [4];
  logic signed [W-1:0] rnx, rny;
  logic [1:0] ridx;
  logic signed [PEN_W-1:0] best;
  logic sep, done;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  find_axis_least_penetration dut (
    .clk(clk), .rst(rst), .start(start),
    .normA0_x(nax[0]), .normA1_x(nax[1]), .normA2_x(nax[2]), .normA3_x(nax[3]),
    .normA0_y(nay[0]), .normA1_y(nay[1]), .normA2_y(nay[2]), .normA3_y(nay[3]),
    .vertA0_x(vax[0]), .vertA1_x(vax[1]), .vertA2_x(vax[2]), .vertA3_x(vax[3]),
    .vertA0_y(vay[0]), .vertA1_y(vay[1]), .vertA2_y(vay[2]), .vertA3_y(vay[3]),
    .vertB0_x(vbx[0]), .vertB1_x(vbx[1]), .vertB2_x(vbx[2]), .vertB3_x(vbx[3]),
    .vertB0_y(vby[0]), .vertB1_y(vby[1]), .vertB2_y(vby[2]), .vertB3_y(vby[3]),
    .referenceNorm_x(rnx), .referenceNorm_y(rny), .referenceIndex(ridx),
    .bestPenetration(best), .separating(sep), .done_out(done)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic setup_a();
    int nx [4] = '{256, 0, -256, 0};
    int ny [4] = '{0, 256, 0, -256};
    int px [4] = '{10, 10, -10, -10};
    int py [4] = '{-10, 10, 10, -10};
    for (int i = 0; i < 4; i++) begin
      nax[i] = W'(nx[i]); nay[i] = W'(ny[i]);
      vax[i] = W'(px[i]); vay[i] = W'(py[i]);
    end
  endtask
  task automatic set_b(input int sx);
    int px [4] = '{10, 10, -10, -10};
    int py [4] = '{-10, 10, 10, -10};
    for (int i = 0; i < 4; i++) begin
      vbx[i] = W'(px[i] + sx); vby[i] = W'(py[i]);
    end
  endtask
  task automatic pulse_start();
    start = 1;
    tick();
    start = 0;
  endtask
  task automatic run_to_done(input string name);
    int n = 0;
    pulse_start();
    while (!done && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout: done_out=%0b after %0d cycles, required 1", name, done, n);
    end
  endtask
  task automatic test_reset();
    setup_a();
    set_b(15);
    rst = 1;
    tick();
    tick();
    rst = 0;
    checks++;
    if (done !== 1'b0 || ridx !== 2'd0 || best !== '0 || sep !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: done=%0b idx=%0d best=%0d sep=%0b, required 0 0 0 1", done, ridx, best, sep);
    end
    checks++;
    if (rnx !== W'(256) || rny !== W'(0)) begin
      errors++;
      $display("FAIL reset_norm: norm=(%0d,%0d), required (256,0)", rnx, rny);
    end
  endtask
  task automatic test_overlap();
    set_b(15);
    run_to_done("overlap");
    checks++;
    if (ridx !== 2'd0 || best !== PEN_W'(-1280)) begin
      errors++;
      $display("FAIL overlap_result: idx=%0d best=%0d, required 0 -1280", ridx, best);
    end
    checks++;
    if (rnx !== W'(256) || rny !== W'(0) || sep !== 1'b0) begin
      errors++;
      $display("FAIL overlap_norm: norm=(%0d,%0d) sep=%0b, required (256,0) 0", rnx, rny, sep);
    end
  endtask
  task automatic test_separated();
    set_b(30);
    run_to_done("separated");
    checks++;
    if (ridx !== 2'd0 || best !== PEN_W'(2560) || sep !== 1'b1) begin
      errors++;
      $display("FAIL separated_result: idx=%0d best=%0d sep=%0b, required 0 2560 1", ridx, best, sep);
    end
  endtask
  task automatic test_tie();
    set_b(0);
    run_to_done("tie");
    checks++;
    if (ridx !== 2'd0 || best !== PEN_W'(-5120) || sep !== 1'b0) begin
      errors++;
      $display("FAIL tie_result: idx=%0d best=%0d sep=%0b, required 0 -5120 0", ridx, best, sep);
    end
  endtask
  task automatic test_face2_wins();
    // B shifted -15: face 2 now has the shallowest penetration (-1280)
    set_b(-15);
    run_to_done("face2");
    checks++;
    if (ridx !== 2'd2 || best !== PEN_W'(-1280) || rnx !== W'(-256) || rny !== W'(0)) begin
      errors++;
      $display("FAIL face2_result: idx=%0d best=%0d norm=(%0d,%0d), required 2 -1280 (-256,0)", ridx, best, rnx, rny);
    end
  endtask
  task automatic test_latency();
    int early = 0;
    set_b(15);
    pulse_start();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL latency_clear: done_out=%0b after start edge, required 0", done);
    end
    for (int i = 1; i < 20; i++) begin
      tick();
      if (done) early++;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL latency_early: done_out high on %0d of edges E+1..E+19, required 0", early);
    end
    tick();
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL latency_e20: done_out=%0b after E+20, required 1", done);
    end
    repeat (5) tick();
    checks++;
    if (done !== 1'b1 || best !== PEN_W'(-1280)) begin
      errors++;
      $display("FAIL latency_hold: done=%0b best=%0d, required 1 -1280", done, best);
    end
  endtask
  task automatic test_restart();
    int early = 0;
    set_b(15);
    pulse_start();
    repeat (6) tick();
    set_b(30);
    pulse_start();
    for (int i = 0; i < 19; i++) begin
      tick();
      if (done) early++;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL restart_early: done_out high on %0d edges before E+27, required 0", early);
    end
    tick();
    checks++;
    if (done !== 1'b1 || ridx !== 2'd0 || best !== PEN_W'(2560) || sep !== 1'b1) begin
      errors++;
      $display("FAIL restart_result: done=%0b idx=%0d best=%0d sep=%0b, required 1 0 2560 1", done, ridx, best, sep);
    end
  endtask
  task automatic test_reset_mid();
    set_b(15);
    pulse_start();
    repeat (9) tick();
    rst = 1;
    tick();
    rst = 0;
    checks++;
    if (done !== 1'b0 || ridx !== 2'd0 || best !== '0) begin
      errors++;
      $display("FAIL reset_mid: done=%0b idx=%0d best=%0d, required 0 0 0", done, ridx, best);
    end
    repeat (30) tick();
    checks++;
    if (done !== 1'b0 || ridx !== 2'd0 || best !== '0 || sep !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle: done=%0b idx=%0d best=%0d sep=%0b, required 0 0 0 1", done, ridx, best, sep);
    end
  endtask
  initial begin
    test_reset();
    test_overlap();
    test_separated();
    test_tie();
    test_face2_wins();
    test_latency();
    test_restart();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
